// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: opcodes, FSM states,
// ALU operation codes and the registered opcode class.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // CL_NONE is the cleared value and also what an illegal opcode decodes to.
    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_R      = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_IMM    = 3'd5
    } class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port between the controller (master) and the memory (slave).
interface multicycle_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);

endinterface

// File: rtl/opcode_class_dec.sv
// Combinational opcode -> instruction class decoder with illegal-opcode flag.
module opcode_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output class_t     o_class,
    output logic       o_illegal
);

    // Map the five supported major opcodes; everything else is illegal
    always_comb begin
        o_class   = CL_NONE;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_R:      o_class = CL_R;
            OP_LOAD:   o_class = CL_LOAD;
            OP_STORE:  o_class = CL_STORE;
            OP_BRANCH: o_class = CL_BRANCH;
            OP_IMM:    o_class = CL_IMM;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory
// port, with retired-instruction counter and sticky illegal-opcode trap.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [6:0]        opcode,
    multicycle_ctrl_if.master mem,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              alu_src,
    output logic [1:0]        alu_op,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              trap,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    class_t           w_dec_class;
    logic             w_dec_illegal;
    logic             r_fetch_pend;
    logic             w_fetch_pend;
    logic             w_retire;
    logic             w_mem_req;
    logic             w_mem_we;
    logic             w_iord;
    logic [CNT_W-1:0] r_cnt;

    opcode_class_dec u_dec (
        .i_opcode  (opcode),
        .o_class   (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

    // State, pending-fetch flag, registered class and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_fetch_pend <= 1'b0;
            r_class      <= CL_NONE;
            r_cnt        <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_next;
            r_fetch_pend <= w_fetch_pend;
            if (r_state == S_DECODE) begin
                r_class <= w_dec_class;
            end else begin
                r_class <= r_class;
            end
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Next-state and strobe decode from state plus registered class
    always_comb begin
        w_next        = r_state;
        w_fetch_pend  = 1'b0;
        w_retire      = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_iord        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        trap          = 1'b0;
        case (r_state)
            S_FETCH: begin
                // run only opens a request; once issued the pending flag holds it.
                // rst_n gating keeps the port quiet while reset is asserted.
                w_mem_req = rst_n & (run | r_fetch_pend);
                if (w_mem_req && mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else begin
                    w_fetch_pend = w_mem_req;
                end
            end
            S_DECODE: begin
                if (w_dec_illegal) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    CL_R: begin
                        alu_op = ALU_FUNCT;
                        w_next = S_WB;
                    end
                    CL_IMM: begin
                        alu_src = 1'b1;
                        w_next  = S_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src = 1'b1;
                        w_next  = S_MEM;
                    end
                    CL_BRANCH: begin
                        alu_op        = ALU_SUB;
                        pc_write_cond = 1'b1;
                        w_retire      = 1'b1;
                        w_next        = S_FETCH;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = (r_class == CL_STORE);
                if (mem.mem_ready) begin
                    if (r_class == CL_STORE) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_class == CL_LOAD);
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign mem.mem_req = w_mem_req;
    assign mem.mem_we  = w_mem_we;
    assign mem.iord    = w_iord;
    assign retire_cnt  = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a 32-bit-counter and a 4-bit-counter
// instance run in lockstep against a per-cycle expected-strobe trace.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       trap;
    } outs_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        run    = 1'b0;
    logic [6:0]  opcode = 7'd0;

    logic        a_ir_write, a_pc_write, a_pc_write_cond, a_alu_src, a_reg_write, a_mem_to_reg, a_trap;
    logic        b_ir_write, b_pc_write, b_pc_write_cond, b_alu_src, b_reg_write, b_mem_to_reg, b_trap;
    logic [1:0]  a_alu_op, b_alu_op;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_cnt = 32'd0;

    outs_t       exp_q[$];
    logic        rdy_q[$];
    logic        run_q[$];
    logic [6:0]  op_q[$];

    multicycle_ctrl_if ifa ();
    multicycle_ctrl_if ifb ();

    multicycle_ctrl #(.CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem(ifa.master),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond),
        .alu_src(a_alu_src), .alu_op(a_alu_op), .reg_write(a_reg_write),
        .mem_to_reg(a_mem_to_reg), .trap(a_trap), .retire_cnt(a_cnt)
    );

    multicycle_ctrl #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem(ifb.master),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
        .alu_src(b_alu_src), .alu_op(b_alu_op), .reg_write(b_reg_write),
        .mem_to_reg(b_mem_to_reg), .trap(b_trap), .retire_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    function automatic outs_t obs_a();
        return {ifa.mem_req, ifa.mem_we, ifa.iord, a_ir_write, a_pc_write, a_pc_write_cond,
                a_alu_src, a_alu_op, a_reg_write, a_mem_to_reg, a_trap};
    endfunction

    function automatic outs_t obs_b();
        return {ifb.mem_req, ifb.mem_we, ifb.iord, b_ir_write, b_pc_write, b_pc_write_cond,
                b_alu_src, b_alu_op, b_reg_write, b_mem_to_reg, b_trap};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic void push(input outs_t e, input logic rdy, input logic rn, input logic [6:0] op);
        exp_q.push_back(e);
        rdy_q.push_back(rdy);
        run_q.push_back(rn);
        op_q.push_back(op);
    endfunction

    // Reference trace for one instruction: idle cycles, fetch waits, then the
    // class-dependent phase sequence. Illegal opcodes stop after DECODE.
    function automatic void build_instr(input logic [6:0] op, input int idle, input int wf, input int wm);
        outs_t e;
        logic  is_ld  = (op == OP_LOAD);
        logic  is_st  = (op == OP_STORE);
        logic  is_br  = (op == OP_BRANCH);
        logic  is_r   = (op == OP_R);
        logic  legal  = is_ld | is_st | is_br | is_r | (op == OP_IMM);
        for (int i = 0; i < idle; i++) begin
            e = '0;
            push(e, rbit(), 1'b0, 7'($urandom));
        end
        for (int i = 0; i < wf; i++) begin
            e = '0;
            e.mem_req = 1'b1;
            push(e, 1'b0, (i == 0) ? 1'b1 : rbit(), 7'($urandom));
        end
        e = '0;
        e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(e, 1'b1, (wf == 0) ? 1'b1 : rbit(), 7'($urandom));
        e = '0;
        push(e, rbit(), rbit(), op);
        if (!legal) return;
        e = '0;
        if (is_r) e.alu_op = 2'b10;
        else if (is_br) begin e.alu_op = 2'b01; e.pc_write_cond = 1'b1; end
        else e.alu_src = 1'b1;
        push(e, rbit(), rbit(), op);
        if (is_br) begin model_cnt = model_cnt + 32'd1; return; end
        if (is_ld || is_st) begin
            e = '0;
            e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = is_st;
            for (int i = 0; i < wm; i++) push(e, 1'b0, rbit(), op);
            push(e, 1'b1, rbit(), op);
            if (is_st) begin model_cnt = model_cnt + 32'd1; return; end
        end
        e = '0;
        e.reg_write = 1'b1; e.mem_to_reg = is_ld;
        push(e, rbit(), rbit(), op);
        model_cnt = model_cnt + 32'd1;
    endfunction

    task automatic play(output outs_t oa, output outs_t ob, output outs_t e);
        logic rdy;
        e             = exp_q.pop_front();
        rdy           = rdy_q.pop_front();
        ifa.mem_ready = rdy;
        ifb.mem_ready = rdy;
        run           = run_q.pop_front();
        opcode        = op_q.pop_front();
        @(negedge clk);
        oa = obs_a();
        ob = obs_b();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; ifa.mem_ready = 1'b1; ifb.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs_a() !== '0 || obs_b() !== '0) $display("FAIL reset_outs: a=%h b=%h expected 0", obs_a(), obs_b());
        else n_pass++;
        n_checks++;
        if (a_cnt !== 32'd0 || b_cnt !== 4'd0) $display("FAIL reset_cnt: a=%0d b=%0d expected 0", a_cnt, b_cnt);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_cnt = 32'd0;
    endtask

    task automatic test_seq(input string name, input logic [6:0] op, input int wf, input int wm);
        outs_t oa, ob, e;
        int    cyc = 0;
        build_instr(op, 0, wf, wm);
        while (exp_q.size() > 0) begin
            play(oa, ob, e);
            n_checks++;
            if (oa !== e || ob !== e) $display("FAIL %s cyc%0d: a=%h b=%h expected=%h", name, cyc, oa, ob, e);
            else n_pass++;
            cyc++;
        end
        n_checks++;
        if (a_cnt !== model_cnt || b_cnt !== model_cnt[3:0])
            $display("FAIL %s_cnt: a=%0d b=%0d expected=%0d", name, a_cnt, b_cnt, model_cnt);
        else n_pass++;
    endtask

    task automatic test_trap();
        outs_t oa, ob, e;
        int    cyc = 0;
        build_instr(7'b1111111, 1, 1, 0);
        e = '0;
        e.trap = 1'b1;
        for (int i = 0; i < 20; i++) push(e, rbit(), rbit(), 7'($urandom));
        while (exp_q.size() > 0) begin
            play(oa, ob, e);
            n_checks++;
            if (oa !== e || ob !== e) $display("FAIL trap cyc%0d: a=%h b=%h expected=%h", cyc, oa, ob, e);
            else n_pass++;
            cyc++;
        end
        n_checks++;
        if (a_cnt !== model_cnt || b_cnt !== model_cnt[3:0])
            $display("FAIL trap_cnt: a=%0d b=%0d expected=%0d", a_cnt, b_cnt, model_cnt);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_a() !== '0 || obs_b() !== '0 || a_cnt !== 32'd0)
            $display("FAIL trap_reset: a=%h b=%h cnt=%0d expected 0", obs_a(), obs_b(), a_cnt);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_cnt = 32'd0;
        test_seq("post_trap_r", OP_R, 0, 0);
    endtask

    task automatic test_async_reset_mid_mem();
        outs_t oa, ob, e;
        build_instr(OP_LOAD, 0, 0, 6);
        for (int i = 0; i < 5; i++) begin
            play(oa, ob, e);
            n_checks++;
            if (oa !== e || ob !== e) $display("FAIL mid_mem cyc%0d: a=%h b=%h expected=%h", i, oa, ob, e);
            else n_pass++;
        end
        exp_q.delete(); rdy_q.delete(); run_q.delete(); op_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifa.mem_req !== 1'b0 || obs_a() !== '0 || obs_b() !== '0)
            $display("FAIL async_reset_outs: a=%h b=%h expected 0", obs_a(), obs_b());
        else n_pass++;
        n_checks++;
        if (a_cnt !== 32'd0 || b_cnt !== 4'd0) $display("FAIL async_reset_cnt: a=%0d b=%0d expected 0", a_cnt, b_cnt);
        else n_pass++;
        model_cnt = 32'd0;
        run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        e = '0;
        for (int i = 0; i < 3; i++) push(e, rbit(), 1'b0, 7'($urandom));
        for (int i = 0; i < 3; i++) begin
            play(oa, ob, e);
            n_checks++;
            if (oa !== e || ob !== e) $display("FAIL idle_after_reset cyc%0d: a=%h b=%h expected=%h", i, oa, ob, e);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) test_seq("wrap_imm", OP_IMM, $urandom_range(1, 0), 0);
        n_checks++;
        if (b_cnt !== 4'd0 || a_cnt !== 32'd16) $display("FAIL wrap_final: a=%0d b=%0d expected 16/0", a_cnt, b_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0] legal_ops [5];
        outs_t      oa, ob, e;
        int         cyc = 0;
        legal_ops = '{OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM};
        for (int n = 0; n < 24; n++) begin
            build_instr(legal_ops[$urandom_range(4, 0)], $urandom_range(2, 0),
                        $urandom_range(3, 0), $urandom_range(3, 0));
            while (exp_q.size() > 0) begin
                play(oa, ob, e);
                n_checks++;
                if (oa !== e || ob !== e) $display("FAIL random cyc%0d: a=%h b=%h expected=%h", cyc, oa, ob, e);
                else n_pass++;
                cyc++;
            end
            n_checks++;
            if (a_cnt !== model_cnt || b_cnt !== model_cnt[3:0])
                $display("FAIL random_cnt: a=%0d b=%0d expected=%0d", a_cnt, b_cnt, model_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_seq("r_type", OP_R, 0, 0);
        test_seq("load_waits", OP_LOAD, 2, 2);
        test_seq("store", OP_STORE, 0, 0);
        test_seq("branch", OP_BRANCH, 0, 0);
        test_trap();
        test_async_reset_mid_mem();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the single-datapath RV32 core. Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control strobes per state.
- Shares one memory port between instruction fetch and data access using a req/ready handshake.
- Counts retired instructions and traps on unsupported opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  fetch enable; sampled only in FETCH before a request is issued
- opcode  in  7  instr[6:0] from the IR; valid from DECODE onward
- mem_ready  in  1  memory completion; qualified by mem_req
- mem_req  out  1  memory access request
- mem_we  out  1  write request (SW data phase only)
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  PC <= PC+4
- pc_write_cond  out  1  PC <= branch target if ALU zero
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 1 = memory data register
- trap  out  1  illegal opcode seen; sticky
- retire_cnt  out  CNT_W  instructions completed

Behaviour:
- Reset (async, rst_n=0):
  - State goes to FETCH with no request pending.
  - All outputs 0, retire_cnt = 0, opcode class register cleared.
  - Reset mid-handshake abandons the access; mem_req drops immediately.
- Opcode classes, decoded in DECODE and registered for use in later states:
  - R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, IMM 0010011.
  - Any other opcode is ILLEGAL.
- FETCH:
  - With run=1: mem_req=1, iord=0, mem_we=0.
  - While mem_ready=0, hold: mem_req, iord and mem_we stay stable.
  - On the cycle with mem_ready=1: ir_write=1 and pc_write=1 (combinational on mem_ready), next state DECODE.
  - With run=0: mem_req=0, stay in FETCH. Dropping run after the request is issued has no effect until the fetch completes.
- DECODE: all strobes 0. Register the class. ILLEGAL -> TRAP; otherwise -> EXEC.
- EXEC:
  - R: alu_src=0, alu_op=10 -> WB.
  - IMM: alu_src=1, alu_op=00 -> WB.
  - LOAD/STORE: alu_src=1, alu_op=00 -> MEM.
  - BRANCH: alu_src=0, alu_op=01, pc_write_cond=1; retire; -> FETCH.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for STORE only.
  - Hold until mem_ready, same rules as FETCH.
  - On mem_ready: LOAD -> WB; STORE retires -> FETCH.
- WB: reg_write=1, mem_to_reg=1 for LOAD only; retire; -> FETCH.
- TRAP:
  - trap=1, all other strobes 0, no retire.
  - Absorbing state; only rst_n exits it.
- Retire: retire_cnt increments by 1 on the final cycle of each legal instruction. Wraps all-ones -> 0 with no flag.
- mem_ready while mem_req=0 is ignored.
- Zero-wait latencies (cycles, FETCH inclusive): BRANCH 3, R/IMM/STORE 4, LOAD 5. Each memory wait cycle adds 1.
- Strobes other than ir_write/pc_write are Moore functions of state plus registered class. They must be glitch-free across holds.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM)
  - state encoding (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP)
  - ALUOp constants (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10)
  - opcode class encoding
- One sub-module: opcode_class_dec, combinational opcode -> {class, illegal}.
- FSM, output decode and counter live in multicycle_ctrl.

Test Plan:
- Reset, then run=1, mem_ready=1 always; opcode=0110011 → states F,D,E,W over 4 cycles; reg_write=1 only in cycle 4, alu_op=10 in E; retire_cnt=1.
- opcode=0000011, mem_ready low 2 cycles in both FETCH and MEM → mem_req/iord stable during waits; ir_write one cycle; mem_to_reg=1 with reg_write in WB; total 9 cycles; retire_cnt=1.
- opcode=0100011 then 1100011, zero-wait → mem_we=1 only in MEM with iord=1; pc_write_cond=1 in the BRANCH EXEC cycle; retire_cnt=2 after 7 cycles.
- opcode=1111111 → TRAP after DECODE; trap=1 held 20 cycles; retire_cnt unchanged; rst_n pulse clears trap, state returns to FETCH.
- rst_n asserted asynchronously mid-MEM wait → mem_req drops without a clock edge; all outputs 0, retire_cnt=0; run=0 after reset keeps mem_req=0.
- CNT_W=4, 16 IMM instructions → retire_cnt wraps 15→0 with no other side effects.
